// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for MULT/MULTU.
// One lookahead-adder step per cycle; product lands in HI/LO.

// Parallel-prefix carry-lookahead adder used for each shift-add step.
module mult_cla #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_co
);

  // Generate/propagate prefix tree; carry into bit i is group G[i-1].
  always_comb begin
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] h;
    g = i_a & i_b;
    p = i_a ^ i_b;
    h = p;
    for (int d = 1; d < W; d = d * 2) begin
      for (int i = W - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    o_sum = h ^ {g[W-2:0], 1'b0};
    o_co  = g[W-1];
  end

endmodule

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] P_ONE = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  // Upper accumulator bit is always zero after the shift, so it is not stored.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_mcand;
  logic             r_neg;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_add_sum;
  logic               w_add_co;
  logic [WIDTH-1:0]   w_step_sum;
  logic               w_step_co;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res;

  // Signed magnitudes; 0x80..0 maps to itself, which unsigned math handles.
  assign w_a_mag = (sign & a[WIDTH-1]) ? (~a + W_ONE) : a;
  assign w_b_mag = (sign & b[WIDTH-1]) ? (~b + W_ONE) : b;

  mult_cla #(.W(WIDTH)) u_cla (
    .i_a   (r_acc),
    .i_b   (r_mcand),
    .o_sum (w_add_sum),
    .o_co  (w_add_co)
  );

  assign w_step_sum = r_mplier[0] ? w_add_sum : r_acc;
  assign w_step_co  = r_mplier[0] & w_add_co;

  assign w_prod = {r_acc, r_mplier};
  assign w_res  = r_neg ? (~w_prod + P_ONE) : w_prod;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: IDLE -> CALC for WIDTH steps -> FIX -> IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands, shift-add steps, signed fix-up into HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= {w_step_co, w_step_sum[WIDTH-1:1]};
          r_mplier <= {w_step_sum[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + C_ONE;
        end
        S_FIX: begin
          {r_hi, r_lo} <= w_res;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Testbench for mult_unit.
// Directed ops feed a scoreboard; a monitor checks each done pulse.

module tb_mult_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [63:0] prod;
    int          t0;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] m_prev = '0;
  logic        prev_done = 1'b0;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: pop expected product on each done, check latency,
  // pulse width and that HI/LO hold during an op.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", {63'd0, done}, 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: got done=1 want no pending op");
        end else begin
          e_mon = sb.pop_front();
          check({e_mon.name, "_prod"}, {hi, lo}, e_mon.prod);
          check({e_mon.name, "_lat"}, 64'(cyc - e_mon.t0), 64'd33);
          m_prev = e_mon.prod;
        end
      end else if (busy) begin
        check("hold", {hi, lo}, m_prev);
      end
      prev_done = done;
    end
  end

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (k < 40 && !done) begin
      @(negedge clk);
      if (!done) k++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done want done", nm);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string nm, input logic s,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input logic [63:0] prod);
    exp_t e;
    sign  = s;
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = prod;
    e.t0   = cyc;
    e.name = nm;
    sb.push_back(e);
    start = 1'b0;
    sign  = ~s;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    @(negedge clk);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int seen;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1_u7x6", 1'b0, 32'd7, 32'd6, 64'd42);
    run_op("t2_umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001);
    run_op("t3_sneg", 1'b1, 32'hFFFF_FFFE, 32'd3,
           64'hFFFF_FFFF_FFFF_FFFA);
    run_op("t3_uneg", 1'b0, 32'hFFFF_FFFE, 32'd3,
           64'h0000_0002_FFFF_FFFA);
    run_op("t4_smin", 1'b1, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000);
    run_op("t4_sm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    run_op("s5xm3", 1'b1, 32'd5, 32'hFFFF_FFFD,
           64'hFFFF_FFFF_FFFF_FFF1);
    run_op("s0xmin", 1'b1, 32'd0, 32'h8000_0000, 64'd0);

    // T5: start pulses while busy must be ignored.
    sign  = 1'b0;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = 64'd15;
    e.t0   = cyc;
    e.name = "t5_ign";
    sb.push_back(e);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) break;
      start = (k == 5 || k == 20);
      a = start ? 32'd100 : 32'd3;
      b = start ? 32'd100 : 32'd5;
    end
    start = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL t5_ign_timeout: got no done want done");
    end
    run_op("t5_b2b", 1'b0, 32'd2, 32'd9, 64'd18);

    // T6: reset mid-CALC discards the op.
    sign  = 1'b0;
    a     = 32'h0000_FFFF;
    b     = 32'h0000_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    m_prev = '0;
    sb.delete();
    #1;
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_done", {63'd0, done}, 64'd0);
    check("t6_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("t6_nodone", 64'(seen), 64'd0);
    run_op("t6_after", 1'b0, 32'd4, 32'd4, 64'd16);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
